max_pool_1d: RTL and testbench
==============================

# max_pool_1d

Streaming, multi-channel 1-D max-pooling stage for the 1-D CNN datapath. It sits between the convolution output and the next layer. It takes a channel-interleaved stream of sign-magnitude samples and emits one maximum per channel per non-overlapping window of `POOL_SIZE` samples. ReLU can optionally be fused into the output. Input and output use valid/ready handshakes, so the stage accepts and emits one sample per cycle under backpressure.

## Interface
- `DATA_WIDTH`, 16: sample width, sign-magnitude (MSB = sign, rest = magnitude); must be ≥ 2.
- `POOL_SIZE`, 2: window length per channel; must be ≥ 1; stride equals `POOL_SIZE`.
- `CHANNELS`, 1: number of interleaved channels; must be ≥ 1.
- `RELU_EN`, 1: 1 clamps negative results to zero; 0 gives a true sign-magnitude max.

Ports:
- `clk`  input  1  system clock, all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  `DATA_WIDTH`  input sample.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  stage can accept a beat this cycle.
- `in_last`  input  1  last input beat of a frame; qualified by `in_valid && in_ready`.
- `out_data`  output  `DATA_WIDTH`  pooled result.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts `out_data`.
- `out_last`  output  1  last pooled result of the frame; valid with `out_valid`.
- `out_ch`  output  `clog2(CHANNELS)` (min 1)  channel index of `out_data`.
- `frame_done`  output  1  one-cycle pulse one cycle after an accepted `in_last` beat.

## Operation
- **Beat:** a beat is accepted when `in_valid && in_ready`.
- **Channel order:** beats arrive in order ch0, ch1, …, ch(`CHANNELS`-1), then repeat.
- **Counters:** channel counter `ch_cnt` runs 0..`CHANNELS`-1 and advances per accepted beat. Position counter `pos_cnt` runs 0..`POOL_SIZE`-1 and advances when `ch_cnt` wraps from `CHANNELS`-1 to 0.
- **Accumulators:** one `DATA_WIDTH` register per channel, `acc[ch]`.
  - `pos_cnt==0`: `acc[ch_cnt] <= in_data`.
  - `0 < pos_cnt < POOL_SIZE-1`: `acc[ch_cnt] <= max(acc[ch_cnt], in_data)`.
  - `pos_cnt==POOL_SIZE-1`: result `r = max(acc[ch_cnt], in_data)`, or `in_data` when `POOL_SIZE==1`, is loaded into the output register with `out_ch = ch_cnt`.
- **max(a,b), sign-magnitude:**
  - Signs differ: pick the non-negative one.
  - Both non-negative: pick the larger magnitude; on a tie pick b.
  - Both negative: pick the smaller magnitude; on a tie pick b.
  - -0 (MSB=1, magnitude 0) is treated as negative. max(+0, -0) = +0.
- **ReLU:** if `RELU_EN=1` and `r` has MSB=1, `out_data` is all zeros (this includes -0). Output is never negative in this mode.
- **Frame end, window complete:** `in_last` accepted with `pos_cnt==POOL_SIZE-1` and `ch_cnt==CHANNELS-1` sets `out_last=1` on that result.
- **Frame end, partial window:** `in_last` accepted in any other state drops the partial window. No result is emitted for the accepted beat, and `out_last` is not generated for that frame.
- **Counter reset on frame end:** any accepted `in_last` resets `ch_cnt` and `pos_cnt` to 0 on the same edge. Accumulator contents become don't-care; they are overwritten at the next `pos_cnt==0`.
- **Handshake:** `in_ready = !out_valid || out_ready`, a single-entry output register with pass-through ready.
  - `out_valid` sets when a result is loaded.
  - `out_valid` clears when `out_valid && out_ready` and no new result is loaded in the same cycle.
  - `out_data`, `out_ch` and `out_last` are stable while `out_valid && !out_ready`.
- **No internal stall:** `in_valid` with `in_ready=0` changes no state.

## Timing
- **Reset:** `rst_n` low asynchronously forces:
  - `out_valid=0`, `out_data=0`, `out_ch=0`, `out_last=0`, `frame_done=0`;
  - `ch_cnt=0`, `pos_cnt=0`, all `acc=0`.
  - `in_ready` reads 1 during reset.
- **Mid-frame reset:** reset asserted mid-window or mid-frame discards all partial state. The first beat after release is ch0, position 0.
- **Latency:** `out_valid` is high on the cycle after the edge that accepted the final beat of a window, i.e. 1 cycle.
- **Throughput:** one input beat per cycle with `out_ready` held high. One output per `POOL_SIZE` input beats per channel.
- **Simultaneous events:** an output handshake and a new result load in the same cycle leave `out_valid=1` with the new data; there is no bubble.
- **Frame boundary:** `frame_done` pulses for exactly one cycle, on the cycle after the `in_last` acceptance edge, independent of `out_ready`.

## Test plan
- **Basic ReLU:** `RELU_EN=1`, `POOL_SIZE=2`, `CHANNELS=1`; inputs 0x0003, 0x0007 -> `out_data`=0x0007.
  - Inputs 0x8005, 0x8002 -> 0x0000.
  - Inputs 0x8005, 0x0001 -> 0x0001.
- **True sign-magnitude max:** `RELU_EN=0`, same config; inputs 0x8005, 0x8002 -> 0x8002.
  - Inputs 0x8000, 0x0000 -> 0x0000.
  - Inputs 0x0004, 0x0004 -> 0x0004.
- **Multi-channel:** `CHANNELS=3`, `POOL_SIZE=3`; streamed 1,9,4 / 5,2,8 / 3,6,7 in ch0,ch1,ch2 order, all positive -> outputs (ch0,5), (ch1,9), (ch2,8) on consecutive cycles, `out_last` on ch2 when `in_last` is on the 9th beat.
- **Backpressure:** `out_ready`=0 for 5 cycles while results are pending -> `in_ready`=0 and `out_data` held constant; no beat is lost or duplicated against a reference model over 1000 random beats with random `in_valid`/`out_ready`.
- **Partial window:** `POOL_SIZE=4`, `in_last` on the 6th beat (`CHANNELS=1`) -> exactly one output (max of beats 1–4), no `out_last`, `frame_done` pulse; the next frame's first window starts fresh.
- **Reset mid-operation:** assert `rst_n`=0 after 3 beats of a `POOL_SIZE=4` window -> all outputs go to 0 immediately; after release, 4 new beats produce one correct result.

Source files
------------

// File: rtl/max_pool_1d.sv
// Streaming multi-channel 1-D max-pool over sign-magnitude samples, with optional fused ReLU.
// Single-entry output register with pass-through ready; counters restart on every accepted frame end.
module max_pool_1d #(
   parameter int DATA_WIDTH = 16,
   parameter int POOL_SIZE  = 2,
   parameter int CHANNELS   = 1,
   parameter bit RELU_EN    = 1'b1
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic [DATA_WIDTH-1:0]                               in_data,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic                                                in_last,
   output logic [DATA_WIDTH-1:0]                               out_data,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic                                                out_last,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  out_ch,
   output logic                                                frame_done
);

   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int POS_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
   localparam int MAG_W = DATA_WIDTH - 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(POOL_SIZE - 1);

   // Sign-magnitude max; -0 counts as negative and ties return b.
   function automatic logic [DATA_WIDTH-1:0] smMax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      logic             aNeg;
      logic             bNeg;
      logic [MAG_W-1:0] aMag;
      logic [MAG_W-1:0] bMag;
      logic [DATA_WIDTH-1:0] res;
      aNeg = a[DATA_WIDTH-1];
      bNeg = b[DATA_WIDTH-1];
      aMag = a[MAG_W-1:0];
      bMag = b[MAG_W-1:0];
      if (aNeg != bNeg) begin
         res = aNeg ? b : a;
      end else if (!aNeg) begin
         res = (aMag > bMag) ? a : b;
      end else begin
         res = (aMag < bMag) ? a : b;
      end
      return res;
   endfunction

   logic [CH_W-1:0]       chCnt_q, chCnt_d;
   logic [POS_W-1:0]      posCnt_q, posCnt_d;
   logic [DATA_WIDTH-1:0] acc_q [2**CH_W];
   logic [DATA_WIDTH-1:0] outData_q, outData_d;
   logic [CH_W-1:0]       outCh_q, outCh_d;
   logic                  outValid_q, outValid_d;
   logic                  outLast_q, outLast_d;
   logic                  frameDone_q, frameDone_d;

   logic                  accept;
   logic                  isLastPos;
   logic                  loadResult;
   logic [DATA_WIDTH-1:0] winResult;
   logic [DATA_WIDTH-1:0] accNext;

   assign in_ready   = !outValid_q || out_ready;
   assign accept     = in_valid && in_ready;
   assign isLastPos  = (posCnt_q == POS_LAST);
   // A frame end that does not close the last channel's window drops the beat's result.
   assign loadResult = accept && isLastPos && (!in_last || (chCnt_q == CH_LAST));
   assign winResult  = (POOL_SIZE == 1) ? in_data : smMax(acc_q[chCnt_q], in_data);
   assign accNext    = (posCnt_q == '0) ? in_data : smMax(acc_q[chCnt_q], in_data);

   always_comb begin
      chCnt_d     = chCnt_q;
      posCnt_d    = posCnt_q;
      outData_d   = outData_q;
      outCh_d     = outCh_q;
      outValid_d  = outValid_q;
      outLast_d   = outLast_q;
      frameDone_d = accept && in_last;

      if (accept) begin
         if (in_last) begin
            chCnt_d  = '0;
            posCnt_d = '0;
         end else if (chCnt_q == CH_LAST) begin
            chCnt_d  = '0;
            posCnt_d = isLastPos ? '0 : posCnt_q + POS_W'(1);
         end else begin
            chCnt_d  = chCnt_q + CH_W'(1);
         end
      end

      if (loadResult) begin
         outValid_d = 1'b1;
         outData_d  = (RELU_EN && winResult[DATA_WIDTH-1]) ? '0 : winResult;
         outCh_d    = chCnt_q;
         outLast_d  = in_last;
      end else if (out_ready) begin
         outValid_d = 1'b0;
         outLast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chCnt_q     <= '0;
         posCnt_q    <= '0;
         outData_q   <= '0;
         outCh_q     <= '0;
         outValid_q  <= 1'b0;
         outLast_q   <= 1'b0;
         frameDone_q <= 1'b0;
         for (int i = 0; i < 2**CH_W; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         chCnt_q     <= chCnt_d;
         posCnt_q    <= posCnt_d;
         outData_q   <= outData_d;
         outCh_q     <= outCh_d;
         outValid_q  <= outValid_d;
         outLast_q   <= outLast_d;
         frameDone_q <= frameDone_d;
         if (accept && !isLastPos) begin
            acc_q[chCnt_q] <= accNext;
         end
      end
   end

   assign out_data   = outData_q;
   assign out_valid  = outValid_q;
   assign out_last   = outLast_q;
   assign out_ch     = outCh_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_max_pool_1d.sv
// Bench for max_pool_1d: four configurations share one input stream and are reset between tests.
module tb_max_pool_1d;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] inData;
   logic        inValid;
   logic        inLast;
   logic        outReady;

   always #5 clk = ~clk;

   // A: P2 C1 ReLU, B: P2 C1 true max, C: P3 C3 true max, D: P4 C1 ReLU
   logic        aInReady, aOutValid, aOutLast, aFrameDone;
   logic [15:0] aOutData;
   logic [0:0]  aOutCh;
   logic        bInReady, bOutValid, bOutLast, bFrameDone;
   logic [15:0] bOutData;
   logic [0:0]  bOutCh;
   logic        cInReady, cOutValid, cOutLast, cFrameDone;
   logic [15:0] cOutData;
   logic [1:0]  cOutCh;
   logic        dInReady, dOutValid, dOutLast, dFrameDone;
   logic [15:0] dOutData;
   logic [0:0]  dOutCh;

   max_pool_1d #(.DATA_WIDTH(16), .POOL_SIZE(2), .CHANNELS(1), .RELU_EN(1'b1)) dutA (
      .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(aInReady),
      .in_last(inLast), .out_data(aOutData), .out_valid(aOutValid), .out_ready(outReady),
      .out_last(aOutLast), .out_ch(aOutCh), .frame_done(aFrameDone));

   max_pool_1d #(.DATA_WIDTH(16), .POOL_SIZE(2), .CHANNELS(1), .RELU_EN(1'b0)) dutB (
      .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(bInReady),
      .in_last(inLast), .out_data(bOutData), .out_valid(bOutValid), .out_ready(outReady),
      .out_last(bOutLast), .out_ch(bOutCh), .frame_done(bFrameDone));

   max_pool_1d #(.DATA_WIDTH(16), .POOL_SIZE(3), .CHANNELS(3), .RELU_EN(1'b0)) dutC (
      .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(cInReady),
      .in_last(inLast), .out_data(cOutData), .out_valid(cOutValid), .out_ready(outReady),
      .out_last(cOutLast), .out_ch(cOutCh), .frame_done(cFrameDone));

   max_pool_1d #(.DATA_WIDTH(16), .POOL_SIZE(4), .CHANNELS(1), .RELU_EN(1'b1)) dutD (
      .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(dInReady),
      .in_last(inLast), .out_data(dOutData), .out_valid(dOutValid), .out_ready(outReady),
      .out_last(dOutLast), .out_ch(dOutCh), .frame_done(dFrameDone));

   typedef struct {
      logic [15:0] beatA;
      logic [15:0] beatB;
      logic [15:0] expRelu;
      logic [15:0] expTrue;
   } vecT;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  ch;
   } expT;

   int          checks = 0;
   int          errors = 0;
   vecT         vecs [9];
   logic [15:0] mcVals [9];
   logic [16:0] dSeen [$];
   int          dFrameDoneCount;
   expT         expQ [$];
   logic [15:0] winVals [3][3];
   int          mCh;
   int          mPos;

   task automatic applyStimulus(input logic [15:0] data, input logic valid, input logic last);
      @(posedge clk);
      #1;
      inData  = data;
      inValid = valid;
      inLast  = last;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      inValid = 1'b0;
      inLast  = 1'b0;
      inData  = '0;
      rstN    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstN    = 1'b1;
   endtask

   // Orders sign-magnitude values on an integer line where -0 sits just below +0.
   function automatic logic [15:0] refMax(input logic [15:0] a, input logic [15:0] b);
      int ka;
      int kb;
      ka = a[15] ? -2 * int'(a[14:0]) : 2 * int'(a[14:0]) + 1;
      kb = b[15] ? -2 * int'(b[14:0]) : 2 * int'(b[14:0]) + 1;
      return (ka > kb) ? a : b;
   endfunction

   task automatic modelBeat(input logic [15:0] d);
      expT e;
      winVals[mCh][mPos] = d;
      if (mPos == 2) begin
         e.data = refMax(refMax(winVals[mCh][0], winVals[mCh][1]), winVals[mCh][2]);
         e.ch   = 2'(mCh);
         expQ.push_back(e);
      end
      if (mCh == 2) begin
         mCh  = 0;
         mPos = (mPos == 2) ? 0 : mPos + 1;
      end else begin
         mCh = mCh + 1;
      end
   endtask

   task automatic checkRandOutput();
      expT e;
      if (cOutValid && outReady) begin
         if (expQ.size() == 0) begin
            checkOutput("rand_unexpected_output", {16'h0, cOutData}, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("rand_data", cOutData, e.data);
            checkOutput("rand_ch", cOutCh, e.ch);
            checkOutput("rand_last", cOutLast, 1'b0);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rstN && dOutValid && outReady) dSeen.push_back({dOutLast, dOutData});
      if (rstN && dFrameDone) dFrameDoneCount++;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic accepted;
      int   beats;
      int   cyc;

      vecs[0] = '{16'h0003, 16'h0007, 16'h0007, 16'h0007};
      vecs[1] = '{16'h8005, 16'h8002, 16'h0000, 16'h8002};
      vecs[2] = '{16'h8005, 16'h0001, 16'h0001, 16'h0001};
      vecs[3] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
      vecs[4] = '{16'h0004, 16'h0004, 16'h0004, 16'h0004};
      vecs[5] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
      vecs[6] = '{16'h0009, 16'h0002, 16'h0009, 16'h0009};
      vecs[7] = '{16'h8001, 16'h8001, 16'h0000, 16'h8001};
      vecs[8] = '{16'h8000, 16'h8003, 16'h0000, 16'h8000};
      mcVals  = '{16'd1, 16'd9, 16'd4, 16'd5, 16'd2, 16'd8, 16'd3, 16'd6, 16'd7};

      // Reset state, sampled before any clock edge with downstream stalled
      outReady = 1'b0;
      inValid  = 1'b0;
      inLast   = 1'b0;
      inData   = '0;
      rstN     = 1'b0;
      #3;
      checkOutput("reset_out_valid", aOutValid, 1'b0);
      checkOutput("reset_out_data", aOutData, 16'h0);
      checkOutput("reset_out_ch", cOutCh, 2'd0);
      checkOutput("reset_out_last", aOutLast, 1'b0);
      checkOutput("reset_frame_done", aFrameDone, 1'b0);
      checkOutput("reset_in_ready", aInReady, 1'b1);
      @(negedge clk);
      rstN = 1'b1;

      // Pairwise windows on the ReLU and true-max instances
      outReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].beatA, 1'b1, 1'b0);
         applyStimulus(vecs[i].beatB, 1'b1, 1'b0);
         applyStimulus(16'h0, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("relu_valid_%0d", i), aOutValid, 1'b1);
         checkOutput($sformatf("relu_data_%0d", i), aOutData, vecs[i].expRelu);
         checkOutput($sformatf("true_valid_%0d", i), bOutValid, 1'b1);
         checkOutput($sformatf("true_data_%0d", i), bOutData, vecs[i].expTrue);
      end

      // Three interleaved channels, window of three, frame ends on the 9th beat
      doReset();
      outReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(mcVals[i], 1'b1, (i == 8));
         @(negedge clk);
         if (i == 6) checkOutput("mc_no_early_output", cOutValid, 1'b0);
         if (i == 7) begin
            checkOutput("mc_ch0_valid", cOutValid, 1'b1);
            checkOutput("mc_ch0_data", cOutData, 16'd5);
            checkOutput("mc_ch0_ch", cOutCh, 2'd0);
            checkOutput("mc_ch0_last", cOutLast, 1'b0);
         end
         if (i == 8) begin
            checkOutput("mc_ch1_valid", cOutValid, 1'b1);
            checkOutput("mc_ch1_data", cOutData, 16'd9);
            checkOutput("mc_ch1_ch", cOutCh, 2'd1);
            checkOutput("mc_ch1_last", cOutLast, 1'b0);
         end
      end
      applyStimulus(16'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mc_ch2_valid", cOutValid, 1'b1);
      checkOutput("mc_ch2_data", cOutData, 16'd8);
      checkOutput("mc_ch2_ch", cOutCh, 2'd2);
      checkOutput("mc_ch2_last", cOutLast, 1'b1);
      checkOutput("mc_frame_done_pulse", cFrameDone, 1'b1);
      applyStimulus(16'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mc_drained", cOutValid, 1'b0);
      checkOutput("mc_frame_done_clear", cFrameDone, 1'b0);

      // Held result under backpressure, then asynchronous reset while it is pending
      doReset();
      outReady = 1'b0;
      applyStimulus(16'h0003, 1'b1, 1'b0);
      applyStimulus(16'h0007, 1'b1, 1'b0);
      applyStimulus(16'h0100, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_in_ready_%0d", k), aInReady, 1'b0);
         checkOutput($sformatf("bp_valid_%0d", k), aOutValid, 1'b1);
         checkOutput($sformatf("bp_data_%0d", k), aOutData, 16'h0007);
         @(posedge clk);
      end
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("bp_reset_valid", aOutValid, 1'b0);
      checkOutput("bp_reset_data", aOutData, 16'h0);
      checkOutput("bp_reset_in_ready", aInReady, 1'b1);
      inValid = 1'b0;
      @(negedge clk);
      rstN = 1'b1;

      // Partial window dropped by in_last on the 6th beat, then a fresh frame
      doReset();
      outReady = 1'b1;
      dSeen.delete();
      dFrameDoneCount = 0;
      applyStimulus(16'h0002, 1'b1, 1'b0);
      applyStimulus(16'h0011, 1'b1, 1'b0);
      applyStimulus(16'h8007, 1'b1, 1'b0);
      applyStimulus(16'h0005, 1'b1, 1'b0);
      applyStimulus(16'h0030, 1'b1, 1'b0);
      applyStimulus(16'h0001, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("partial_output_count", dSeen.size(), 1);
      if (dSeen.size() > 0) checkOutput("partial_output", dSeen[0], {1'b0, 16'h0011});
      checkOutput("partial_frame_done_count", dFrameDoneCount, 1);
      dSeen.delete();
      dFrameDoneCount = 0;
      applyStimulus(16'h0003, 1'b1, 1'b0);
      applyStimulus(16'h0004, 1'b1, 1'b0);
      applyStimulus(16'h0002, 1'b1, 1'b0);
      applyStimulus(16'h0001, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fresh_output_count", dSeen.size(), 1);
      if (dSeen.size() > 0) checkOutput("fresh_output_with_last", dSeen[0], {1'b1, 16'h0004});
      checkOutput("fresh_frame_done_count", dFrameDoneCount, 1);

      // Reset after three beats of a four-beat window discards the partial window
      doReset();
      outReady = 1'b1;
      applyStimulus(16'h0050, 1'b1, 1'b0);
      applyStimulus(16'h0060, 1'b1, 1'b0);
      applyStimulus(16'h0070, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("midreset_valid", dOutValid, 1'b0);
      checkOutput("midreset_data", dOutData, 16'h0);
      checkOutput("midreset_in_ready", dInReady, 1'b1);
      @(negedge clk);
      rstN = 1'b1;
      dSeen.delete();
      applyStimulus(16'h0001, 1'b1, 1'b0);
      applyStimulus(16'h0009, 1'b1, 1'b0);
      applyStimulus(16'h0003, 1'b1, 1'b0);
      applyStimulus(16'h0002, 1'b1, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("midreset_output_count", dSeen.size(), 1);
      if (dSeen.size() > 0) checkOutput("midreset_output", dSeen[0], {1'b0, 16'h0009});

      // Random valid/ready on the three-channel true-max instance against a window model
      doReset();
      expQ.delete();
      mCh      = 0;
      mPos     = 0;
      beats    = 0;
      cyc      = 0;
      accepted = 1'b0;
      while (beats < 1000 && cyc < 6000) begin
         @(posedge clk);
         #1;
         if (!inValid || accepted) begin
            inValid = ($urandom_range(0, 3) != 0);
            inData  = 16'($urandom);
         end
         inLast   = 1'b0;
         outReady = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         accepted = inValid && cInReady;
         if (accepted) begin
            modelBeat(inData);
            beats++;
         end
         checkRandOutput();
         cyc++;
      end
      checkOutput("rand_beat_budget", beats, 1000);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         inValid  = 1'b0;
         outReady = 1'b1;
         @(negedge clk);
         checkRandOutput();
      end
      checkOutput("rand_all_outputs_seen", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
